// File: rtl/gfx_barycentric.sv
// Barycentric weight generator: turns two edge-function values and the doubled
// triangle area into three fixed-point weights using two bit-serial restoring dividers.
module gfx_barycentric #(
    parameter int point_width  = 16,
    parameter int factor_width = 16
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            write_i,
    input  logic [point_width-1:0]          x_counter_i,
    input  logic [point_width-1:0]          y_counter_i,
    input  logic signed [2*point_width-1:0] triangle_edge0_i,
    input  logic signed [2*point_width-1:0] triangle_edge1_i,
    input  logic signed [2*point_width-1:0] triangle_area_i,
    output logic                            ack_o,
    output logic                            write_o,
    input  logic                            ack_i,
    output logic [point_width-1:0]          x_counter_o,
    output logic [point_width-1:0]          y_counter_o,
    output logic [factor_width:0]           factor0_o,
    output logic [factor_width:0]           factor1_o,
    output logic [factor_width:0]           factor2_o
);

    localparam int ew  = 2 * point_width;
    localparam int rw  = ew + 1;
    localparam int fw1 = factor_width + 1;
    localparam int cw  = $clog2(factor_width + 2);
    localparam logic [fw1-1:0] one_c       = {1'b1, {factor_width{1'b0}}};
    localparam logic [cw-1:0]  last_step_c = cw'(factor_width);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DIV      = 2'd1,
        ST_WRITE    = 2'd2,
        ST_WAIT_ACK = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [point_width-1:0] x_q, x_d, y_q, y_d;
    logic signed [ew-1:0]   area_q, area_d;
    logic [rw-1:0]          rem0_q, rem0_d, rem1_q, rem1_d;
    logic [fw1-1:0]         quo0_q, quo0_d, quo1_q, quo1_d;
    logic                   sat0_q, sat0_d, sat1_q, sat1_d;
    logic [cw-1:0]          cnt_q, cnt_d;
    logic [point_width-1:0] x_o_q, x_o_d, y_o_q, y_o_d;
    logic [fw1-1:0]         f0_q, f0_d, f1_q, f1_d, f2_q, f2_d;
    logic                   write_o_q, write_o_d, ack_o_q, ack_o_d;

    logic [ew-1:0]  edge0_c_s, edge1_c_s;
    logic [rw:0]    step0_s, step1_s;
    logic [fw1-1:0] quo0_next_s, quo1_next_s, fin0_s, fin1_s;

    // The numerator is edge << factor_width, so its low bits are all zero: the
    // remainder starts at the edge value and shifts in zeros, one quotient bit per step.
    function automatic logic [rw:0] div_step(input logic [rw-1:0] rem, input logic [rw-1:0] den);
        logic          ge;
        logic [rw-1:0] diff;
        ge   = (rem >= den);
        diff = ge ? (rem - den) : rem;
        return {diff[rw-2:0], 1'b0, ge};
    endfunction

    function automatic logic [fw1-1:0] third_factor(input logic [fw1-1:0] a, input logic [fw1-1:0] b);
        logic signed [fw1+1:0] full;
        full = $signed({2'b00, one_c}) - $signed({2'b00, a}) - $signed({2'b00, b});
        return full[fw1+1] ? {fw1{1'b0}} : full[fw1-1:0];
    endfunction

    assign edge0_c_s   = triangle_edge0_i[ew-1] ? {ew{1'b0}} : triangle_edge0_i;
    assign edge1_c_s   = triangle_edge1_i[ew-1] ? {ew{1'b0}} : triangle_edge1_i;
    assign step0_s     = div_step(rem0_q, {1'b0, area_q});
    assign step1_s     = div_step(rem1_q, {1'b0, area_q});
    assign quo0_next_s = {quo0_q[fw1-2:0], step0_s[0]};
    assign quo1_next_s = {quo1_q[fw1-2:0], step1_s[0]};
    assign fin0_s      = sat0_q ? one_c : quo0_next_s;
    assign fin1_s      = sat1_q ? one_c : quo1_next_s;

    // Next-state and datapath update for the pixel handshake FSM.
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        area_d    = area_q;
        rem0_d    = rem0_q;
        rem1_d    = rem1_q;
        quo0_d    = quo0_q;
        quo1_d    = quo1_q;
        sat0_d    = sat0_q;
        sat1_d    = sat1_q;
        cnt_d     = cnt_q;
        x_o_d     = x_o_q;
        y_o_d     = y_o_q;
        f0_d      = f0_q;
        f1_d      = f1_q;
        f2_d      = f2_q;
        write_o_d = 1'b0;
        ack_o_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (write_i) begin
                    x_d     = x_counter_i;
                    y_d     = y_counter_i;
                    area_d  = triangle_area_i;
                    rem0_d  = {1'b0, edge0_c_s};
                    rem1_d  = {1'b0, edge1_c_s};
                    quo0_d  = {fw1{1'b0}};
                    quo1_d  = {fw1{1'b0}};
                    sat0_d  = (edge0_c_s > $unsigned(triangle_area_i));
                    sat1_d  = (edge1_c_s > $unsigned(triangle_area_i));
                    cnt_d   = {cw{1'b0}};
                    state_d = ST_DIV;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DIV: begin
                if (area_q[ew-1] || (area_q == {ew{1'b0}})) begin
                    x_o_d   = x_q;
                    y_o_d   = y_q;
                    f0_d    = {fw1{1'b0}};
                    f1_d    = {fw1{1'b0}};
                    f2_d    = one_c;
                    state_d = ST_WRITE;
                end else begin
                    rem0_d = step0_s[rw:1];
                    rem1_d = step1_s[rw:1];
                    quo0_d = quo0_next_s;
                    quo1_d = quo1_next_s;
                    cnt_d  = cnt_q + cw'(1);
                    if (cnt_q == last_step_c) begin
                        x_o_d   = x_q;
                        y_o_d   = y_q;
                        f0_d    = fin0_s;
                        f1_d    = fin1_s;
                        f2_d    = third_factor(fin0_s, fin1_s);
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_DIV;
                    end
                end
            end
            ST_WRITE: begin
                write_o_d = 1'b1;
                state_d   = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (ack_i) begin
                    ack_o_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_ACK;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers, cleared asynchronously by reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= ST_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            area_q    <= '0;
            rem0_q    <= '0;
            rem1_q    <= '0;
            quo0_q    <= '0;
            quo1_q    <= '0;
            sat0_q    <= 1'b0;
            sat1_q    <= 1'b0;
            cnt_q     <= '0;
            x_o_q     <= '0;
            y_o_q     <= '0;
            f0_q      <= '0;
            f1_q      <= '0;
            f2_q      <= '0;
            write_o_q <= 1'b0;
            ack_o_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            area_q    <= area_d;
            rem0_q    <= rem0_d;
            rem1_q    <= rem1_d;
            quo0_q    <= quo0_d;
            quo1_q    <= quo1_d;
            sat0_q    <= sat0_d;
            sat1_q    <= sat1_d;
            cnt_q     <= cnt_d;
            x_o_q     <= x_o_d;
            y_o_q     <= y_o_d;
            f0_q      <= f0_d;
            f1_q      <= f1_d;
            f2_q      <= f2_d;
            write_o_q <= write_o_d;
            ack_o_q   <= ack_o_d;
        end
    end

    assign write_o     = write_o_q;
    assign ack_o       = ack_o_q;
    assign x_counter_o = x_o_q;
    assign y_counter_o = y_o_q;
    assign factor0_o   = f0_q;
    assign factor1_o   = f1_q;
    assign factor2_o   = f2_q;

endmodule

// File: tb/tb_gfx_barycentric.sv
// Directed bench for gfx_barycentric: latency, division results, handshake and reset.
module tb_gfx_barycentric;

    localparam int PW = 16;
    localparam int FW = 16;
    localparam logic [63:0] ONE = 64'd65536;

    logic                   clk, rst_n, write_i, ack_i, ack_o, write_o;
    logic [PW-1:0]          x_i, y_i, x_o, y_o;
    logic signed [2*PW-1:0] e0, e1, area;
    logic [FW:0]            f0, f1, f2;

    int total = 0;
    int bad   = 0;

    gfx_barycentric #(.point_width(PW), .factor_width(FW)) dut (
        .clk_i(clk), .rst_i(rst_n), .write_i(write_i),
        .x_counter_i(x_i), .y_counter_i(y_i),
        .triangle_edge0_i(e0), .triangle_edge1_i(e1), .triangle_area_i(area),
        .ack_o(ack_o), .write_o(write_o), .ack_i(ack_i),
        .x_counter_o(x_o), .y_counter_o(y_o),
        .factor0_o(f0), .factor1_o(f1), .factor2_o(f2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic send(input int x, input int y, input int ed0, input int ed1, input int ar);
        x_i = PW'(x); y_i = PW'(y);
        e0 = 32'(ed0); e1 = 32'(ed1); area = 32'(ar);
        write_i = 1'b1;
        @(posedge clk); #1;
        write_i = 1'b0;
    endtask

    task automatic expect_result(input string tag, input int lat_exp, input int x, input int y,
                                 input logic [63:0] ef0, input logic [63:0] ef1, input logic [63:0] ef2);
        int lat = 0;
        while (write_o !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_lat"}, 64'(lat), 64'(lat_exp));
        chk({tag, "_x"}, 64'(x_o), 64'(x));
        chk({tag, "_y"}, 64'(y_o), 64'(y));
        chk({tag, "_f0"}, 64'(f0), ef0);
        chk({tag, "_f1"}, 64'(f1), ef1);
        chk({tag, "_f2"}, 64'(f2), ef2);
    endtask

    task automatic ack_now(input string tag);
        ack_i = 1'b1;
        @(posedge clk); #1;
        ack_i = 1'b0;
        chk({tag, "_ack_pulse"}, 64'(ack_o), 64'd1);
        chk({tag, "_wr_drop"}, 64'(write_o), 64'd0);
        @(posedge clk); #1;
        chk({tag, "_ack_end"}, 64'(ack_o), 64'd0);
    endtask

    task automatic quiet(input string tag, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (write_o === 1'b1 || ack_o === 1'b1) seen++;
        end
        chk({tag, "_quiet"}, 64'(seen), 64'd0);
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_wr"}, 64'(write_o), 64'd0);
        chk({tag, "_ack"}, 64'(ack_o), 64'd0);
        chk({tag, "_xy"}, {32'(x_o), 32'(y_o)}, 64'd0);
        chk({tag, "_f"}, {15'd0, f0, f1, f2[13:0]}, 64'd0);
        chk({tag, "_f2"}, 64'(f2), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; write_i = 1'b0; ack_i = 1'b0;
        x_i = '0; y_i = '0; e0 = '0; e1 = '0; area = '0;
        repeat (3) @(posedge clk);
        #1;
        all_zero("reset");

        // write_i already high on the first edge after reset release
        rst_n = 1'b1;
        send(10, 20, 1, 1, 4);
        expect_result("quarter", 18, 10, 20, 64'h4000, 64'h4000, 64'h8000);
        ack_now("quarter");

        send(3, 4, 1, 1, 3);
        expect_result("third", 18, 3, 4, 64'h5555, 64'h5555, 64'h5556);
        ack_now("third");

        send(5, 6, -5, 7, 5);
        expect_result("sat", 18, 5, 6, 64'd0, ONE, 64'd0);
        ack_now("sat");

        send(7, 8, 3, 3, 4);
        expect_result("f2clamp", 18, 7, 8, 64'd49152, 64'd49152, 64'd0);
        ack_now("f2clamp");

        send(1, 2, 4, 0, 4);
        expect_result("equal", 18, 1, 2, ONE, 64'd0, 64'd0);
        ack_now("equal");

        send(1234, 4321, 1000, 2000, 7000);
        expect_result("big", 18, 1234, 4321, 64'd9362, 64'd18724, 64'd37450);
        ack_now("big");

        send(11, 12, 5, 9, 0);
        expect_result("area0", 2, 11, 12, 64'd0, 64'd0, ONE);
        ack_now("area0");

        send(13, 14, 1, 1, -3);
        expect_result("areaneg", 2, 13, 14, 64'd0, 64'd0, ONE);
        ack_now("areaneg");

        // Downstream stalls; a second pixel offered meanwhile must be dropped
        send(30, 40, 1, 1, 4);
        expect_result("stall", 18, 30, 40, 64'h4000, 64'h4000, 64'h8000);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                x_i = 16'd99; y_i = 16'd98; e0 = 32'd1; e1 = 32'd1; area = 32'd2;
                write_i = 1'b1;
            end
            @(posedge clk); #1;
            write_i = 1'b0;
            chk("stall_hold_wr", 64'(write_o), 64'd0);
            chk("stall_hold_ack", 64'(ack_o), 64'd0);
            chk("stall_hold_out", {32'(x_o), 15'd0, f0}, {32'd30, 32'h4000});
        end
        ack_now("stall");
        quiet("stall_drop", 25);

        // Reset five cycles into the divide abandons the pixel
        send(50, 60, 1, 1, 3);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        all_zero("midreset");
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        quiet("midreset", 25);

        send(70, 80, 1, 1, 4);
        expect_result("after", 18, 70, 80, 64'h4000, 64'h4000, 64'h8000);
        ack_now("after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gfx_barycentric.md
GFX_BARYCENTRIC -- requirements
Module: gfx_barycentric

Interface
REQ-001 SHALL have parameter point_width, default 16: integer pixel coordinate width.
REQ-002 SHALL have parameter factor_width, default 16: fraction bits of each factor, so ONE = 2^factor_width.
REQ-003 SHALL have port clk_i, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port write_i, input, 1 bit: one-cycle pixel strobe from the triangle rasterizer.
REQ-006 SHALL have port x_counter_i and y_counter_i, input, point_width bits each: pixel coordinates.
REQ-007 SHALL have port triangle_edge0_i and triangle_edge1_i, input, 2*point_width bits signed: edge function values.
REQ-008 SHALL have port triangle_area_i, input, 2*point_width bits signed: doubled triangle area.
REQ-009 SHALL have port ack_o, output, 1 bit: one-cycle pulse to the rasterizer; pixel fully consumed.
REQ-010 SHALL have port write_o, output, 1 bit: one-cycle result strobe downstream.
REQ-011 SHALL have port ack_i, input, 1 bit: downstream accepted the result.
REQ-012 SHALL have port x_counter_o and y_counter_o, output, point_width bits each: registered pixel coordinates.
REQ-013 SHALL have port factor0_o, factor1_o and factor2_o, output, factor_width+1 bits unsigned: barycentric weights.

Function
REQ-014 SHALL implement a 4-state FSM: IDLE, DIV, WRITE, WAIT_ACK.
REQ-015 SHALL in IDLE, on write_i=1, latch coordinates, edges and area, then enter DIV; write_i in any other state SHALL be ignored.
REQ-016 SHALL on latch clamp a negative edge value to 0.
REQ-017 SHALL in DIV run two restoring dividers in parallel, one quotient bit per cycle, MSB first, for exactly factor_width+1 cycles.
REQ-018 SHALL compute factor0 = floor(edge0*ONE/area) and factor1 = floor(edge1*ONE/area).
REQ-019 SHALL use numerator width 2*point_width+factor_width bits, unsigned.
REQ-020 SHALL saturate each quotient to ONE when edge exceeds area.
REQ-021 SHALL, if the latched area is <= 0, skip DIV and enter WRITE with factor0=factor1=0 and factor2=ONE.
REQ-022 SHALL compute factor2 = ONE - factor0 - factor1, clamped to 0 if negative.
REQ-023 SHALL register all factors together with x_counter_o/y_counter_o on entry to WRITE.
REQ-024 SHALL in WRITE drive write_o=1 for exactly one cycle, then enter WAIT_ACK.
REQ-025 SHALL hold outputs stable in WAIT_ACK until ack_i=1.
REQ-026 SHALL on ack_i=1 in WAIT_ACK pulse ack_o for one cycle and return to IDLE.
REQ-027 SHALL set latency from write_i sampled (cycle N) to write_o high at cycle N+factor_width+2, i.e. N+18 at default.
REQ-028 SHALL set latency on the area <= 0 bypass to write_o at cycle N+2.
REQ-029 SHALL, if ack_i is high on the same cycle as write_o, treat it as accepted: ack_o the next cycle and return to IDLE.
REQ-030 SHALL ignore ack_i outside WRITE/WAIT_ACK.
REQ-031 SHALL make at most one pixel in flight; ack_o SHALL never be asserted without a preceding write_i.

Reset
REQ-032 SHALL while rst_i=0 force state IDLE and all outputs and internal registers to 0, including ack_o, write_o, coordinates and factors.
REQ-033 SHALL on reset mid-DIV or in WAIT_ACK abandon the pixel, with no ack_o or write_o afterwards.
REQ-034 SHALL accept write_i on the first clock edge after rst_i deasserts.

Verification
REQ-035 SHALL verify: edge0=1, edge1=1, area=4, x=10, y=20 -> write_o at N+18; factor0=factor1=0x04000, factor2=0x08000, x_o=10, y_o=20.
REQ-036 SHALL verify: edge0=1, edge1=1, area=3 -> factor0=factor1=0x05555, factor2=0x05556 (truncation).
REQ-037 SHALL verify: edge0=-5, edge1=7, area=5 -> factor0=0, factor1=ONE (saturated), factor2=0.
REQ-038 SHALL verify: area=0 -> write_o at N+2; factor0=factor1=0, factor2=0x10000.
REQ-039 SHALL verify: ack_i held low 10 cycles after write_o -> outputs stable, no ack_o; ack_i=1 -> ack_o pulse the next cycle; a second write_i issued during WAIT_ACK is ignored.
REQ-040 SHALL verify: rst_i low at DIV cycle 5 -> all outputs 0 immediately; no write_o/ack_o after release; a new write_i is processed normally.
